// File: rtl/axiseg_2x128_to_axis256_pkg.sv
// Shared types and widths for the 2x128 segment to 256-bit AXI4-Stream converter.
//   seg_t   : one 128-bit input segment with its per-segment sideband.
//   beat_t  : one assembled 256-bit output beat as held in the beat FIFO.
package axiseg_2x128_to_axis256_pkg;

   localparam int unsigned SEG_DW    = 128;
   localparam int unsigned SEG_MTYW  = 4;
   localparam int unsigned SEG_KW    = SEG_DW / 8;
   localparam int unsigned AXIS_DW   = 256;
   localparam int unsigned AXIS_KW   = 32;
   localparam int unsigned SEG_TIDW  = 3;
   localparam int unsigned AXIS_TIDW = 6;
   localparam int unsigned TDESTW    = 7;

   typedef struct packed {
      logic [SEG_DW-1:0]   tdata;
      logic                ena;
      logic                sop;
      logic                eop;
      logic                err;
      logic [SEG_MTYW-1:0] mty;
   } seg_t;

   typedef struct packed {
      logic [AXIS_DW-1:0]  tdata;
      logic [AXIS_KW-1:0]  tkeep;
      logic                tlast;
      logic [SEG_TIDW-1:0] tid;
      logic                err;
   } beat_t;

   typedef enum logic {
      S_IDLE,
      S_IN_PKT
   } pkt_state_e;

   // Byte-enable mask of an eop segment: the low 16-mty bytes are valid.
   function automatic logic [SEG_KW-1:0] mty_keep(input logic [SEG_MTYW-1:0] mty);
      logic [SEG_KW:0] full;
      full = (SEG_KW+1)'(1) << (SEG_KW - 32'(mty));
      return SEG_KW'(full - (SEG_KW+1)'(1));
   endfunction

   function automatic beat_t mk_beat(input logic [AXIS_DW-1:0]  data,
                                     input logic [AXIS_KW-1:0]  keep,
                                     input logic                last,
                                     input logic                err,
                                     input logic [SEG_TIDW-1:0] tid);
      beat_t b;
      b.tdata = data;
      b.tkeep = keep;
      b.tlast = last;
      b.tid   = tid;
      b.err   = err;
      return b;
   endfunction

endpackage

// File: rtl/axiseg_2x128_to_axis256_if.sv
// Boundary bundle of the converter: segmented input pair plus AXI4-Stream output.
//   slave  : converter view (sinks segments, sources the stream, drives axiseg_ready).
//   master : environment view (sources segments, sinks the stream, drives axis_m_tready).
interface axiseg_2x128_to_axis256_if;
   import axiseg_2x128_to_axis256_pkg::*;

   logic                 axiseg_valid;
   logic                 axiseg_ready;
   logic [SEG_TIDW-1:0]  axiseg_tid;

   logic [SEG_DW-1:0]    axiseg_s0_tdata;
   logic                 axiseg_s0_tuser_ena;
   logic                 axiseg_s0_tuser_sop;
   logic                 axiseg_s0_tuser_eop;
   logic                 axiseg_s0_tuser_err;
   logic [SEG_MTYW-1:0]  axiseg_s0_tuser_mty;

   logic [SEG_DW-1:0]    axiseg_s1_tdata;
   logic                 axiseg_s1_tuser_ena;
   logic                 axiseg_s1_tuser_sop;
   logic                 axiseg_s1_tuser_eop;
   logic                 axiseg_s1_tuser_err;
   logic [SEG_MTYW-1:0]  axiseg_s1_tuser_mty;

   logic                 axis_m_tvalid;
   logic                 axis_m_tready;
   logic [AXIS_DW-1:0]   axis_m_tdata;
   logic [AXIS_KW-1:0]   axis_m_tkeep;
   logic                 axis_m_tlast;
   logic [AXIS_TIDW-1:0] axis_m_tid;
   logic [TDESTW-1:0]    axis_m_tdest;
   logic                 axis_m_tuser_err;

   modport slave (
      input  axiseg_valid, axiseg_tid,
      input  axiseg_s0_tdata, axiseg_s0_tuser_ena, axiseg_s0_tuser_sop,
      input  axiseg_s0_tuser_eop, axiseg_s0_tuser_err, axiseg_s0_tuser_mty,
      input  axiseg_s1_tdata, axiseg_s1_tuser_ena, axiseg_s1_tuser_sop,
      input  axiseg_s1_tuser_eop, axiseg_s1_tuser_err, axiseg_s1_tuser_mty,
      output axiseg_ready,
      input  axis_m_tready,
      output axis_m_tvalid, axis_m_tdata, axis_m_tkeep, axis_m_tlast,
      output axis_m_tid, axis_m_tdest, axis_m_tuser_err
   );

   modport master (
      output axiseg_valid, axiseg_tid,
      output axiseg_s0_tdata, axiseg_s0_tuser_ena, axiseg_s0_tuser_sop,
      output axiseg_s0_tuser_eop, axiseg_s0_tuser_err, axiseg_s0_tuser_mty,
      output axiseg_s1_tdata, axiseg_s1_tuser_ena, axiseg_s1_tuser_sop,
      output axiseg_s1_tuser_eop, axiseg_s1_tuser_err, axiseg_s1_tuser_mty,
      input  axiseg_ready,
      output axis_m_tready,
      input  axis_m_tvalid, axis_m_tdata, axis_m_tkeep, axis_m_tlast,
      input  axis_m_tid, axis_m_tdest, axis_m_tuser_err
   );

endinterface

// File: rtl/axis_beat_fifo.sv
// Output beat FIFO: up to two writes and one read per cycle, with occupancy count.
//   clk, rst_n : clock, async active-low reset (storage cleared so the head reads 0)
//   wr_cnt     : number of beats written this cycle (wr_data0 first, then wr_data1)
//   rd_en      : pop the head beat
//   rd_data    : head beat
//   count      : current occupancy
module axis_beat_fifo
   import axiseg_2x128_to_axis256_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [1:0]                 wr_cnt,
   input  beat_t                      wr_data0,
   input  beat_t                      wr_data1,
   input  logic                       rd_en,
   output beat_t                      rd_data,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   beat_t          mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [CW-1:0]  cnt;

   // Storage and pointers; depth is a power of two so pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_cnt != 2'd0) mem[wr_ptr] <= wr_data0;
         if (wr_cnt == 2'd2) mem[wr_ptr + AW'(1)] <= wr_data1;
         wr_ptr <= wr_ptr + AW'(wr_cnt);
         if (rd_en) rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + CW'(wr_cnt) - CW'(rd_en);
      end
   end

   assign rd_data = mem[rd_ptr];
   assign count   = cnt;

endmodule

// File: rtl/axiseg_2x128_to_axis256.sv
// Packs a stream of 128-bit segment pairs into 256-bit AXI4-Stream beats.
//   aclk, arstn  : clock, async active-low reset
//   bus (slave)  : segment pair input (axiseg_*) and AXI4-Stream output (axis_m_*)
//   err_protocol : sticky flag for a non-sop segment outside a packet or sop inside one
module axiseg_2x128_to_axis256
   import axiseg_2x128_to_axis256_pkg::*;
#(
   parameter int unsigned       FIFO_DEPTH  = 4,
   parameter logic [TDESTW-1:0] TDEST_VALUE = 7'd0
) (
   input  logic                        aclk,
   input  logic                        arstn,
   axiseg_2x128_to_axis256_if.slave    bus,
   output logic                        err_protocol
);

   localparam int unsigned       CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [SEG_KW-1:0] KEEP_ALL  = '1;
   localparam logic [SEG_KW-1:0] KEEP_NONE = '0;

   pkt_state_e          state_q, state_d;
   logic                res_valid_q, res_valid_d;
   logic [SEG_DW-1:0]   res_data_q, res_data_d;
   logic [SEG_TIDW-1:0] tid_q, tid_d;
   logic                err_q, err_d;
   logic                ready_q, ready_d;
   logic                tvalid_q, tvalid_d;

   seg_t                seg [2];
   beat_t               push [2];
   logic [1:0]          n_push;
   logic                t_en, m_en;
   beat_t               t_b, m_b;
   logic                accept;
   logic                pop;
   beat_t               head;
   logic [CW-1:0]       fifo_count;
   logic [CW:0]         fifo_next;

   assign seg[0] = '{tdata: bus.axiseg_s0_tdata, ena: bus.axiseg_s0_tuser_ena,
                     sop: bus.axiseg_s0_tuser_sop, eop: bus.axiseg_s0_tuser_eop,
                     err: bus.axiseg_s0_tuser_err, mty: bus.axiseg_s0_tuser_mty};
   assign seg[1] = '{tdata: bus.axiseg_s1_tdata, ena: bus.axiseg_s1_tuser_ena,
                     sop: bus.axiseg_s1_tuser_sop, eop: bus.axiseg_s1_tuser_eop,
                     err: bus.axiseg_s1_tuser_err, mty: bus.axiseg_s1_tuser_mty};

   assign accept = bus.axiseg_valid & ready_q;
   assign pop    = tvalid_q & bus.axis_m_tready;

   // Assembler: walk s0 then s1, updating packet state and collecting pushed beats.
   always_comb begin
      state_d     = state_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      tid_d       = tid_q;
      err_d       = err_q;
      push[0]     = '0;
      push[1]     = '0;
      n_push      = 2'd0;
      t_en        = 1'b0;
      m_en        = 1'b0;
      t_b         = '0;
      m_b         = '0;

      for (int i = 0; i < 2; i++) begin
         t_en = 1'b0;
         m_en = 1'b0;
         t_b  = '0;
         m_b  = '0;
         if (accept && seg[i].ena) begin
            if (seg[i].sop) begin
               // sop inside a packet closes it as an errored last beat; with no
               // residue pending the closing beat carries no valid bytes.
               if (state_d == S_IN_PKT) begin
                  t_en  = 1'b1;
                  t_b   = mk_beat({SEG_DW'(0), res_valid_d ? res_data_d : SEG_DW'(0)},
                                  {KEEP_NONE, res_valid_d ? KEEP_ALL : KEEP_NONE},
                                  1'b1, 1'b1, tid_d);
                  err_d = 1'b1;
               end
               tid_d = bus.axiseg_tid;
               if (seg[i].eop) begin
                  m_en        = 1'b1;
                  m_b         = mk_beat({SEG_DW'(0), seg[i].tdata},
                                        {KEEP_NONE, mty_keep(seg[i].mty)},
                                        1'b1, seg[i].err, tid_d);
                  state_d     = S_IDLE;
                  res_valid_d = 1'b0;
               end else begin
                  state_d     = S_IN_PKT;
                  res_valid_d = 1'b1;
                  res_data_d  = seg[i].tdata;
               end
            end else if (state_d == S_IDLE) begin
               err_d = 1'b1;
            end else if (!res_valid_d) begin
               if (seg[i].eop) begin
                  m_en    = 1'b1;
                  m_b     = mk_beat({SEG_DW'(0), seg[i].tdata},
                                    {KEEP_NONE, mty_keep(seg[i].mty)},
                                    1'b1, seg[i].err, tid_d);
                  state_d = S_IDLE;
               end else begin
                  res_valid_d = 1'b1;
                  res_data_d  = seg[i].tdata;
               end
            end else begin
               m_en        = 1'b1;
               m_b         = mk_beat({seg[i].tdata, res_data_d},
                                     {seg[i].eop ? mty_keep(seg[i].mty) : KEEP_ALL, KEEP_ALL},
                                     seg[i].eop, seg[i].eop & seg[i].err, tid_d);
               res_valid_d = 1'b0;
               if (seg[i].eop) state_d = S_IDLE;
            end
         end
         // Legal traffic never exceeds two beats per pair; beyond that only
         // back-to-back protocol violations, whose surplus beats are dropped.
         if (t_en && n_push != 2'd2) begin
            push[n_push[0]] = t_b;
            n_push          = n_push + 2'd1;
         end
         if (m_en && n_push != 2'd2) begin
            push[n_push[0]] = m_b;
            n_push          = n_push + 2'd1;
         end
      end

      fifo_next = (CW+1)'(fifo_count) + (CW+1)'(n_push) - (CW+1)'(pop);
      ready_d   = (32'(fifo_next) + 32'd2) <= 32'(FIFO_DEPTH);
      tvalid_d  = fifo_next != '0;
   end

   // Assembler and handshake state registers.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         state_q     <= S_IDLE;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         tid_q       <= '0;
         err_q       <= 1'b0;
         ready_q     <= 1'b0;
         tvalid_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         tid_q       <= tid_d;
         err_q       <= err_d;
         ready_q     <= ready_d;
         tvalid_q    <= tvalid_d;
      end
   end

   axis_beat_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (aclk),
      .rst_n    (arstn),
      .wr_cnt   (n_push),
      .wr_data0 (push[0]),
      .wr_data1 (push[1]),
      .rd_en    (pop),
      .rd_data  (head),
      .count    (fifo_count)
   );

   assign bus.axiseg_ready     = ready_q;
   assign bus.axis_m_tvalid    = tvalid_q;
   assign bus.axis_m_tdata     = head.tdata;
   assign bus.axis_m_tkeep     = head.tkeep;
   assign bus.axis_m_tlast     = head.tlast;
   assign bus.axis_m_tid       = {3'b000, head.tid};
   assign bus.axis_m_tdest     = TDEST_VALUE;
   assign bus.axis_m_tuser_err = head.err;
   assign err_protocol         = err_q;

endmodule
